// File: rtl/bitwise_pkg.sv
// Shared opcode and FSM encodings for the bitwise operation scheduler and its ALU.
package bitwise_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND  = 3'd0;
   localparam logic [OP_W-1:0] OP_OR   = 3'd1;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
   localparam logic [OP_W-1:0] OP_NOTB = 3'd3;
   localparam logic [OP_W-1:0] OP_XNOR = 3'd4;
   localparam logic [OP_W-1:0] OP_RXNR = 3'd5;
   localparam logic [OP_W-1:0] OP_RNND = 3'd6;
   localparam logic [OP_W-1:0] OP_RNOR = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/bitwise_alu.sv
// Combinational bitwise/reduction ALU shared by all requesters.
module bitwise_alu #(
   parameter int W = 4
) (
   input  logic [2:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);
   import bitwise_pkg::*;

   // Reduction results land in bit 0 with the upper bits cleared.
   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NOTB: y = ~b;
         OP_XNOR: y = ~(a ^ b);
         OP_RXNR: y = {{(W-1){1'b0}}, ~^b};
         OP_RNND: y = {{(W-1){1'b0}}, ~&b};
         OP_RNOR: y = {{(W-1){1'b0}}, ~|b};
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/bitwise_op_scheduler.sv
// Round-robin scheduler that shares one bitwise ALU between NUM_REQ requesters,
// holding each result until the consumer accepts it.
module bitwise_op_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int W       = 4,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [3*NUM_REQ-1:0] req_op,
   input  logic [W*NUM_REQ-1:0] req_a,
   input  logic [W*NUM_REQ-1:0] req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [2:0]           rsp_id,
   output logic [W-1:0]         rsp_data,
   output logic [CNT_W-1:0]     op_count
);
   import bitwise_pkg::*;

   state_t         state_q, state_d;
   logic [2:0]     rr_ptr;
   logic [7:0]     valid_pad;
   logic [7:0]     ready_pad;
   logic [3:0]     cand;
   logic           found;
   logic [2:0]     grant;
   logic [2:0]     sel_op;
   logic [W-1:0]   sel_a, sel_b;
   logic           accept;
   logic [2:0]     op_p0;
   logic [W-1:0]   a_p0, b_p0;
   logic [2:0]     g_p0;
   logic [W-1:0]   alu_y;
   logic [2:0]     rr_next;

   // Arbitration: first valid index at or after rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      valid_pad = '0;
      valid_pad[NUM_REQ-1:0] = req_valid;
      found  = 1'b0;
      grant  = '0;
      cand   = '0;
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, rr_ptr} + 4'(i);
         if (cand >= 4'(NUM_REQ))
            cand = cand - 4'(NUM_REQ);
         if (!found && valid_pad[cand[2:0]]) begin
            found = 1'b1;
            grant = cand[2:0];
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == 3'(i)) begin
            sel_op = req_op[3*i +: 3];
            sel_a  = req_a[W*i +: W];
            sel_b  = req_b[W*i +: W];
         end
      end
   end

   assign accept    = (state_q == ST_IDLE) && found && !rst;
   assign ready_pad = 8'd1 << grant;
   assign req_ready = accept ? ready_pad[NUM_REQ-1:0] : '0;
   assign rsp_valid = (state_q == ST_RESP);
   assign rr_next   = (g_p0 == 3'(NUM_REQ-1)) ? 3'd0 : g_p0 + 3'd1;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (found)     state_d = ST_EXEC;
         ST_EXEC:                state_d = ST_RESP;
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // ---- stage p0: operand capture at the accept edge ----
   always_ff @(posedge clk) begin
      if (accept) begin
         op_p0 <= sel_op;
         a_p0  <= sel_a;
         b_p0  <= sel_b;
         g_p0  <= grant;
      end
   end

   bitwise_alu #(.W(W)) u_alu (
      .op (op_p0),
      .a  (a_p0),
      .b  (b_p0),
      .y  (alu_y)
   );

   // ---- stage p1: registered result, pointer advance and completion count ----
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr   <= '0;
         rsp_data <= '0;
         rsp_id   <= '0;
         op_count <= '0;
      end else begin
         if (state_q == ST_EXEC) begin
            rsp_data <= alu_y;
            rsp_id   <= g_p0;
            rr_ptr   <= rr_next;
         end
         if ((state_q == ST_RESP) && rsp_ready)
            op_count <= op_count + 1'b1;
      end
   end

endmodule
